// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encoding and widths for the instruction-memory loader
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CNT_LO = 3'd1,
    CNT_HI = 3'd2,
    DATA   = 3'd3,
    CSUM   = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  localparam logic [7:0] DEFAULT_MAGIC = 8'hA5;
  localparam int         IDX_W         = 2;
  localparam int         CNT_W         = 16;

endpackage

// File: rtl/imem_word_packer.sv
// rtl/imem_word_packer.sv - packs a byte stream into little-endian 32-bit words
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data_byte,
  input  logic        strobe,
  input  logic        clear,
  output logic [31:0] word,
  output logic        word_valid,
  output logic        last_byte
);

  logic [IDX_W-1:0] idx;
  logic [23:0]      shreg;

  // Asserted while the next strobed byte completes a word.
  assign last_byte = &idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx        <= '0;
      shreg      <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        idx <= '0;
      end else if (strobe) begin
        shreg <= {data_byte, shreg[23:8]};
        idx   <= idx + 1'b1;
        if (last_byte) begin
          word       <= {data_byte, shreg};
          word_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader for instruction memory; optional IMEM_LOADER_TIMEOUT_EN idle timeout
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         ADDR_W      = 10,
  parameter logic [7:0] MAGIC       = DEFAULT_MAGIC,
  parameter int         TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam int CAPACITY = 1 << ADDR_W;

  if (ADDR_W < 1 || ADDR_W > CNT_W || TIMEOUT_CYC < 1) begin : g_param_check
    $error("imem_loader: unsupported parameter values");
  end

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n, cnt_full;
  logic [7:0]       csum_q, csum_n;
  logic             done_n, err_n, hold_n;
  logic             acc, start, pk_strobe, pk_last, timeout;

  assign acc      = rx_valid && rx_ready;
  assign cnt_full = {rx_data, cnt_q[7:0]};

  imem_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .data_byte  (rx_data),
    .strobe     (pk_strobe),
    .clear      (start),
    .word       (wr_data),
    .word_valid (wr_en),
    .last_byte  (pk_last)
  );

`ifdef IMEM_LOADER_TIMEOUT_EN
  logic [31:0] idle_cnt;
  logic        active;

  assign active  = (state == CNT_LO) || (state == CNT_HI) || (state == DATA) || (state == CSUM);
  assign timeout = active && !acc && (idle_cnt == 32'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt <= '0;
    end else if (!active || acc || timeout) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 32'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    cnt_n     = cnt_q;
    csum_n    = csum_q;
    done_n    = done;
    err_n     = err;
    hold_n    = cpu_hold;
    start     = 1'b0;
    pk_strobe = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        if (acc && rx_data == MAGIC) begin
          start   = 1'b1;
          state_n = CNT_LO;
          csum_n  = '0;
          done_n  = 1'b0;
          err_n   = 1'b0;
          hold_n  = 1'b1;
        end
      end
      CNT_LO: begin
        if (acc) begin
          cnt_n   = CNT_W'(rx_data);
          csum_n  = csum_q ^ rx_data;
          state_n = CNT_HI;
        end
      end
      CNT_HI: begin
        if (acc) begin
          cnt_n  = cnt_full;
          csum_n = csum_q ^ rx_data;
          if (int'(cnt_full) > CAPACITY) begin
            state_n = ERR;
            err_n   = 1'b1;
          end else if (cnt_full == '0) begin
            state_n = CSUM;
          end else begin
            state_n = DATA;
          end
        end
      end
      DATA: begin
        if (acc) begin
          pk_strobe = 1'b1;
          csum_n    = csum_q ^ rx_data;
          // wr_addr still holds this word's index; its write lands next cycle.
          if (pk_last && CNT_W'(wr_addr) == cnt_q - CNT_W'(1)) begin
            state_n = CSUM;
          end
        end
      end
      CSUM: begin
        if (acc) begin
          if (rx_data == csum_q) begin
            state_n = DONE;
            done_n  = 1'b1;
            hold_n  = 1'b0;
          end else begin
            state_n = ERR;
            err_n   = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (timeout) begin
      state_n = ERR;
      err_n   = 1'b1;
      done_n  = 1'b0;
      hold_n  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rx_ready <= 1'b0;
      cnt_q    <= '0;
      csum_q   <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      cpu_hold <= 1'b1;
      wr_addr  <= '0;
    end else begin
      state    <= state_n;
      rx_ready <= 1'b1;
      cnt_q    <= cnt_n;
      csum_q   <= csum_n;
      done     <= done_n;
      err      <= err_n;
      cpu_hold <= hold_n;
      if (start) begin
        wr_addr <= '0;
      end else if (wr_en) begin
        wr_addr <= wr_addr + 1'b1;
      end
    end
  end

endmodule
